// File: rtl/load_store_seq_if.sv
// load_store_seq_if
//   Command and datapath-control bundle between the main control unit and
//   the load/store/writeback sequencer.
//   master : control-unit side, drives start/op/is_byte and observes the
//            memory, MDR, writeback and status strobes.
//   slave  : sequencer side, the mirror image of master.
//   Signals:
//     start       command strobe
//     op          00 ALU_OUT writeback, 01 load, 10 store, 11 raw ALU writeback
//     is_byte     byte (lbu/sb) vs doubleword (ld/sd) access
//     mem_rd      memory read request
//     mem_wr      memory write strobe
//     mem_byte_en write byte lanes
//     mdr_load    load MEM_REG from memory data
//     wb_sel      writeback-mux select
//     reg_wr      register-file write enable
//     busy        sequencer not idle
//     done        last cycle of a command
interface load_store_seq_if;
  logic       start;
  logic [1:0] op;
  logic       is_byte;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_byte_en;
  logic       mdr_load;
  logic [1:0] wb_sel;
  logic       reg_wr;
  logic       busy;
  logic       done;

  modport master (
    output start, op, is_byte,
    input  mem_rd, mem_wr, mem_byte_en, mdr_load, wb_sel, reg_wr, busy, done
  );

  modport slave (
    input  start, op, is_byte,
    output mem_rd, mem_wr, mem_byte_en, mdr_load, wb_sel, reg_wr, busy, done
  );
endinterface

// File: rtl/load_store_seq.sv
// load_store_seq
//   Multicycle sequencer for the memory/writeback phase of one instruction.
//   A start pulse in IDLE captures op/is_byte and walks the command through
//   RD -> MDR -> WB (load), WB (ALU writeback) or WR (store).
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    load_store_seq_if.slave: command inputs and control strobes
//   Parameter:
//     MEM_LATENCY  cycles mem_rd is held before read data is valid (1..15)
module load_store_seq #(
  parameter int MEM_LATENCY = 2
) (
  input logic             clk,
  input logic             reset,
  load_store_seq_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] MDR  = 3'd2;
  localparam logic [2:0] WB   = 3'd3;
  localparam logic [2:0] WR   = 3'd4;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic [1:0] op_q;
  logic       byte_q;

  // Sequencing: commands are accepted only from IDLE, and op/is_byte are
  // latched at that moment so later input changes cannot disturb a command
  // already in flight. The read wait counter counts down to zero while RD
  // holds mem_rd high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      op_q   <= 2'b00;
      byte_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            byte_q <= bus.is_byte;
            case (bus.op)
              2'b01: begin
                state <= RD;
                cnt   <= LAT_M1;
              end
              2'b10:   state <= WR;
              default: state <= WB;
            endcase
          end
        end
        RD: begin
          if (cnt == 4'd0) state <= MDR;
          else             cnt   <= cnt - 4'd1;
        end
        MDR:     state <= WB;
        WB:      state <= IDLE;
        WR:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode: purely from state and the captured command, so nothing
  // on the command inputs can reach an output combinationally.
  always_comb begin
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_byte_en = 8'h00;
    bus.mdr_load    = 1'b0;
    bus.wb_sel      = 2'b00;
    bus.reg_wr      = 1'b0;
    bus.done        = 1'b0;
    bus.busy        = (state != IDLE);
    case (state)
      RD:  bus.mem_rd   = 1'b1;
      MDR: bus.mdr_load = 1'b1;
      WB: begin
        bus.reg_wr = 1'b1;
        bus.done   = 1'b1;
        case (op_q)
          2'b11:   bus.wb_sel = 2'b01;
          2'b01:   bus.wb_sel = byte_q ? 2'b10 : 2'b11;
          default: bus.wb_sel = 2'b00;
        endcase
      end
      WR: begin
        bus.mem_wr      = 1'b1;
        bus.done        = 1'b1;
        bus.mem_byte_en = byte_q ? 8'h01 : 8'hFF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_seq.sv
// tb_load_store_seq
//   Drives two sequencers (MEM_LATENCY 2 and 1) with identical command
//   streams and compares every cycle's outputs against a command-timeline
//   model: each accepted command is described only by how many cycles it
//   lasts and what is expected at each cycle offset since acceptance.
module tb_load_store_seq;

  logic clk;
  logic reset;

  load_store_seq_if ifa ();
  load_store_seq_if ifb ();

  load_store_seq #(.MEM_LATENCY(2)) dut_lat2 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  load_store_seq #(.MEM_LATENCY(1)) dut_lat1 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state, index 0 = latency 2, index 1 = latency 1.
  bit         active [2];
  int         k      [2];
  logic [1:0] mop    [2];
  logic       mbyte  [2];

  function automatic int latOf(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Total busy cycles of the command currently held by model i.
  function automatic int cmdLen(input int i);
    return (mop[i] == 2'b01) ? latOf(i) + 2 : 1;
  endfunction

  // Expected outputs for the cycle the model is currently in, packed as
  // {busy, done, reg_wr, wb_sel, mdr_load, mem_wr, mem_rd, mem_byte_en}.
  function automatic logic [15:0] expOut(input int i);
    logic       busy, done, regWr, mdrLoad, memWr, memRd;
    logic [1:0] wbSel;
    logic [7:0] byteEn;
    bit         last;
    busy    = active[i];
    last    = active[i] && (k[i] == cmdLen(i));
    done    = last;
    memWr   = active[i] && (mop[i] == 2'b10);
    memRd   = active[i] && (mop[i] == 2'b01) && (k[i] <= latOf(i));
    mdrLoad = active[i] && (mop[i] == 2'b01) && (k[i] == latOf(i) + 1);
    regWr   = last && (mop[i] != 2'b10);
    wbSel   = 2'b00;
    if (regWr) begin
      if (mop[i] == 2'b11)      wbSel = 2'b01;
      else if (mop[i] == 2'b01) wbSel = mbyte[i] ? 2'b10 : 2'b11;
    end
    byteEn = memWr ? (mbyte[i] ? 8'h01 : 8'hFF) : 8'h00;
    return {busy, done, regWr, wbSel, mdrLoad, memWr, memRd, byteEn};
  endfunction

  // Advance model i across one rising edge with the inputs present there.
  task automatic modelStep(input int i, input logic rst, input logic st,
                           input logic [1:0] o, input logic b);
    if (rst) begin
      active[i] = 1'b0;
      k[i]      = 0;
    end else if (active[i]) begin
      if (k[i] == cmdLen(i)) active[i] = 1'b0;
      else                   k[i]++;
    end else if (st) begin
      active[i] = 1'b1;
      k[i]      = 1;
      mop[i]    = o;
      mbyte[i]  = b;
    end
  endtask

  function automatic logic [15:0] packA();
    return {ifa.busy, ifa.done, ifa.reg_wr, ifa.wb_sel, ifa.mdr_load,
            ifa.mem_wr, ifa.mem_rd, ifa.mem_byte_en};
  endfunction

  function automatic logic [15:0] packB();
    return {ifb.busy, ifb.done, ifb.reg_wr, ifb.wb_sel, ifb.mdr_load,
            ifb.mem_wr, ifb.mem_rd, ifb.mem_byte_en};
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s @%0t: got %h expected %h "
               , tag, $time, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the models and
  // compare both DUTs half a cycle later.
  task automatic applyStimulus(input logic rst, input logic st,
                               input logic [1:0] o, input logic b);
    reset       = rst;
    ifa.start   = st;
    ifa.op      = o;
    ifa.is_byte = b;
    ifb.start   = st;
    ifb.op      = o;
    ifb.is_byte = b;
    @(posedge clk);
    modelStep(0, rst, st, o, b);
    modelStep(1, rst, st, o, b);
    @(negedge clk);
    checkOutput("lat2", packA(), expOut(0));
    checkOutput("lat1", packB(), expOut(1));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0;
      k[i]      = 0;
      mop[i]    = 2'b00;
      mbyte[i]  = 1'b0;
    end

    // Reset held with a load command pending: everything stays quiet.
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);

    // Byte load, then idle long enough to see the whole timeline.
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);

    // Doubleword store, then byte store.
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);

    // Raw-ALU then ALU_OUT writeback with start held high throughout.
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);

    // Load, op switched to store during the read, reset during MDR.
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);

    // Doubleword load, run out.
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);

    // Randomized command stream with occasional resets.
    for (int c = 0; c < 400; c++) begin
      logic       rst, st, b;
      logic [1:0] o;
      rst = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 9) < 5);
      o   = 2'($urandom_range(0, 3));
      b   = 1'($urandom_range(0, 1));
      applyStimulus(rst, st, o, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
